bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Shares the single-port word RAM bus between N requesters, e.g. Cpu (port 0) plus a DMA or debug master (port 1).
- Round-robin arbitration, with an optional bounded lock for back-to-back bursts.
- Drives the RAM bus signals `bus_addr`, `bus_data_w` and `bus_mask_w` from the winner.
- Routes the 1-cycle-latency registered read data back to whichever requester issued the read.

Parameters:
- N, 2, number of requesters (2..8); index i selects slice i of every packed per-requester port.
- MAX_HOLD, 4, max consecutive grants a locked requester keeps while another requester is waiting (>=1).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  requester i wants a bus transfer this cycle.
- lock  input  N  requester i asks to keep the bus for its next request (burst).
- addr  input  N*30  word address per requester.
- data_w  input  N*32  write data per requester.
- mask_w  input  N*4  byte write enables per requester; 0 means read.
- gnt  output  N  one-hot or zero; requester i's transfer is performed this cycle.
- rvalid  output  N  read data for requester i is on data_r this cycle.
- data_r  output  32  read data, shared by all requesters.
- bus_addr  output  30  to RAM.
- bus_data_r  input  32  from RAM; registered, valid the cycle after a read.
- bus_data_w  output  32  to RAM.
- bus_mask_w  output  4  to RAM; 0 means read.

Behaviour:
- **State:** `last` (log2 N bits, index of the last grantee), `locked` (1 bit), `hold_cnt` (log2(MAX_HOLD)+1 bits), `rd_vld`, `rd_id`.
- **Grant timing:** `gnt` is combinational from `req` and state in the same cycle. A transfer is exactly one cycle with `gnt[i]` high; there are no wait states.
- **Grant selection, in priority order:**
  1. If `reset`: `gnt` = 0.
  2. Locked owner keeps the bus if all of these hold: `locked`, `req[last]`, and either `hold_cnt < MAX_HOLD` or no other `req` bit set. Then `gnt[last]` = 1.
  3. Otherwise, round-robin: first set `req` bit scanning `last+1, last+2, ...` mod N. The locked owner is excluded from this scan only when it was denied by the hold limit.
  4. If no `req` bit is set: `gnt` = 0.
- **Bus mux, granted:** `bus_addr`, `bus_data_w` and `bus_mask_w` are the granted requester's slices.
- **Bus mux, idle:** `bus_addr` = 0, `bus_data_w` = 0, `bus_mask_w` = 0 (a harmless read of word 0). `bus_mask_w` must never be nonzero without a grant.
- **State update on a grant to i (posedge):**
  - `last` <= i.
  - `locked` <= `lock[i]`.
  - `hold_cnt` <= (i == old `last` && old `locked`) ? `hold_cnt` + 1 : 1, saturating at MAX_HOLD.
- **State update with no grant:** `locked` <= 0, `hold_cnt` <= 0, `last` unchanged.
- **Read return:**
  - `rd_vld` <= grant with `mask_w` == 0; `rd_id` <= grantee.
  - Next cycle: `rvalid[rd_id]` = `rd_vld`, `data_r` = `bus_data_r` (combinational pass-through). `rvalid` is zero elsewhere.
- **Writes:** complete at the grant edge; no `rvalid` is produced.
- **Pipelining:** back-to-back reads from different requesters are legal. The `rvalid` for grant k overlaps grant k+1 and routes correctly by `rd_id`.
- **Reset values:**
  - `last` = N-1, so requester 0 wins first.
  - `locked` = 0, `hold_cnt` = 0, `rd_vld` = 0.
  - Outputs: `gnt` = 0, `rvalid` = 0, `bus_mask_w` = 0, `bus_addr` = 0, `bus_data_w` = 0. `data_r` follows `bus_data_r` and is don't-care while `rvalid` = 0.
- **Reset mid-operation:** a pending read return is dropped (`rvalid` stays 0 the cycle after reset). A write granted in the reset cycle is not issued.
- **Requester contract:** a requester must hold `req` and its payload stable until it sees `gnt`. Deasserting `req` without a grant is legal; the request is simply withdrawn.
- **Lock with req low:** `lock` is ignored when `req` is low. A lock held by a requester that drops `req` is released the next cycle.

Test Plan:
- **Reset arbitration:** N=2, reset, then `req`=11 both reads (addr 5, addr 9) -> cycle 0 `gnt`=01, `bus_addr`=5; cycle 1 `gnt`=10, `bus_addr`=9, `rvalid`=01 with `data_r`=mem[5]; cycle 2 `rvalid`=10 with `data_r`=mem[9].
- **Write then read back:** requester 1 alone writes 0xDEADBEEF mask 1111 to addr 3, then reads addr 3 -> write cycle has `rvalid`=00; the read returns 0xDEADBEEF one cycle after its grant.
- **Hold limit:** requester 0 with `lock`=1 and `req` held high, requester 1 `req` high from the start -> `gnt` = 01 for 4 cycles (MAX_HOLD), then 10, then 01 again.
- **Lock with no contention:** requester 0 locked, requester 1 idle -> `gnt[0]` stays high for 10+ consecutive cycles, no forced rotation.
- **Idle bus:** `req`=00 -> `gnt`=00, `bus_mask_w`=0000, `bus_addr`=0; `locked` clears, so the next contended cycle uses plain round-robin from `last`+1.
- **Reset mid-read:** reset asserted the cycle after a read grant -> `rvalid`=00 that cycle and the next. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Requester-side and RAM-side signals of the shared word-RAM bus arbiter.
// The arbiter uses the slave modport; requesters and the RAM use master.
interface bus_arbiter_if #(
  parameter int N = 2
);
  logic [N-1:0]      req;
  logic [N-1:0]      lock;
  logic [N*30-1:0]   addr;
  logic [N*32-1:0]   data_w;
  logic [N*4-1:0]    mask_w;
  logic [N-1:0]      gnt;
  logic [N-1:0]      rvalid;
  logic [31:0]       data_r;
  logic [29:0]       bus_addr;
  logic [31:0]       bus_data_r;
  logic [31:0]       bus_data_w;
  logic [3:0]        bus_mask_w;

  modport slave (
    input  req, lock, addr, data_w, mask_w, bus_data_r,
    output gnt, rvalid, data_r, bus_addr, bus_data_w, bus_mask_w
  );

  modport master (
    output req, lock, addr, data_w, mask_w, bus_data_r,
    input  gnt, rvalid, data_r, bus_addr, bus_data_w, bus_mask_w
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one single-port word RAM between N requesters,
// with a bounded burst lock and routing of the 1-cycle-latency read data.
module bus_arbiter #(
  parameter int N        = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic          clock,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);
  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  logic [IW-1:0] r_last;
  logic          r_locked;
  logic [HW-1:0] r_holdCnt;
  logic          r_rdVld;
  logic [IW-1:0] r_rdId;

  logic [N-1:0]  w_lastOneHot;
  logic [N-1:0]  w_otherReq;
  logic [N-1:0]  w_scanReq;
  logic          w_keep;
  logic          w_holdDenied;
  logic          w_gntAny;
  logic [IW-1:0] w_gntIdx;

  // Winner selection: a locked owner keeps the bus until the hold limit bites
  // while someone else waits; otherwise scan round-robin starting after last.
  always_comb begin
    w_lastOneHot         = '0;
    w_lastOneHot[r_last] = 1'b1;
    w_otherReq           = bus.req & ~w_lastOneHot;
    w_keep               = r_locked && bus.req[r_last] &&
                           ((r_holdCnt < HOLD_MAX) || (w_otherReq == '0));
    w_holdDenied         = r_locked && bus.req[r_last] && !w_keep;
    w_scanReq            = w_holdDenied ? w_otherReq : bus.req;
    w_gntAny             = 1'b0;
    w_gntIdx             = r_last;
    if (!reset) begin
      if (w_keep) begin
        w_gntAny = 1'b1;
        w_gntIdx = r_last;
      end else begin
        for (int k = N; k >= 1; k--) begin
          if (w_scanReq[(int'(r_last) + k) % N]) begin
            w_gntAny = 1'b1;
            w_gntIdx = IW'((int'(r_last) + k) % N);
          end
        end
      end
    end
  end

  // An idle bus issues a read of word 0 so the RAM never sees a stray write.
  always_comb begin
    bus.gnt        = '0;
    bus.bus_addr   = '0;
    bus.bus_data_w = '0;
    bus.bus_mask_w = '0;
    if (w_gntAny) begin
      bus.gnt[w_gntIdx] = 1'b1;
      bus.bus_addr      = bus.addr[int'(w_gntIdx)*30 +: 30];
      bus.bus_data_w    = bus.data_w[int'(w_gntIdx)*32 +: 32];
      bus.bus_mask_w    = bus.mask_w[int'(w_gntIdx)*4 +: 4];
    end
  end

  // Reset suppresses a read return that was already in flight.
  always_comb begin
    bus.rvalid = '0;
    if (r_rdVld && !reset) begin
      bus.rvalid[r_rdId] = 1'b1;
    end
    bus.data_r = bus.bus_data_r;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_last    <= IW'(N - 1);
      r_locked  <= 1'b0;
      r_holdCnt <= '0;
      r_rdVld   <= 1'b0;
      r_rdId    <= '0;
    end else if (w_gntAny) begin
      r_last   <= w_gntIdx;
      r_locked <= bus.lock[w_gntIdx];
      if ((w_gntIdx == r_last) && r_locked) begin
        r_holdCnt <= (r_holdCnt == HOLD_MAX) ? HOLD_MAX : r_holdCnt + 1'b1;
      end else begin
        r_holdCnt <= HW'(1);
      end
      r_rdVld <= (bus.bus_mask_w == 4'd0);
      r_rdId  <= w_gntIdx;
    end else begin
      r_locked  <= 1'b0;
      r_holdCnt <= '0;
      r_rdVld   <= 1'b0;
    end
  end
endmodule
